sram_responder: RTL and testbench

//   Synthesizable responder for the SLC-3 external-SRAM bus: answers the CPU's active-low
//   CE/UB/LB/OE/WE strobes, 20-bit address and bidirectional 16-bit data with on-chip RAM.

---
 rtl/sram_if.sv | 28 ++
 rtl/sram_responder.sv | 107 ++++++++++
 tb/tb_sram_responder.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/sram_if.sv
// SLC-3 external-SRAM strobe/address bus plus the background word-load handshake.
// The bidirectional data bus stays a plain inout on the responder so tristate resolution happens at a module port.
interface sram_if #(
  parameter int AW = 10
);
  logic          CE;
  logic          UB;
  logic          LB;
  logic          OE;
  logic          WE;
  logic [19:0]   A;
  logic          load_valid;
  logic          load_ready;
  logic [AW-1:0] load_addr;
  logic [15:0]   load_data;

  modport master (
    output CE, UB, LB, OE, WE, A,
    output load_valid, load_addr, load_data,
    input  load_ready
  );

  modport slave (
    input  CE, UB, LB, OE, WE, A,
    input  load_valid, load_addr, load_data,
    output load_ready
  );
endinterface

// File: rtl/sram_responder.sv
// On-chip RAM answering the SLC-3 SRAM strobes, with a background load port and
// a self-clear of every word after each (synchronised) reset release.
module sram_responder #(
  parameter int DEPTH = 1024,
  parameter int AW    = 10
) (
  input  logic       Clk,
  input  logic       Reset,
  sram_if.slave      bus,
  inout  wire [15:0] I_O,
  output logic       busy,
  output logic       oob_err
);

  typedef enum logic {CLEAR, IDLE} state_t;

  state_t        state;
  logic [1:0]    rst_sync;
  logic          rst_n;
  logic [AW-1:0] clr_idx;
  logic [15:0]   rd_q;
  logic [1:0]    drv_q;

  logic [15:0]   mem [DEPTH];
  logic [1:0]    mem_we;
  logic [AW-1:0] mem_idx;
  logic [15:0]   mem_wd;

  logic          in_range;
  logic [AW-1:0] idx;
  logic          wr_acc;
  logic          rd_acc;
  logic          load_fire;

  // Assertion is immediate; release is delayed two edges.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) rst_sync <= '0;
    else        rst_sync <= {rst_sync[0], 1'b1};
  end
  assign rst_n = rst_sync[1];

  assign in_range  = (bus.A[19:AW] == '0);
  assign idx       = bus.A[AW-1:0];
  assign wr_acc    = !bus.CE && !bus.WE;
  assign rd_acc    = !bus.CE &&  bus.WE && !bus.OE;
  assign load_fire = bus.load_valid && bus.load_ready;

  assign bus.load_ready = (state == IDLE) && bus.CE;

  // Single write port: clear sweep, CPU byte writes, then load words (never concurrent with CPU).
  always_comb begin
    mem_we  = '0;
    mem_idx = idx;
    mem_wd  = I_O;
    if (state == CLEAR) begin
      mem_we  = '1;
      mem_idx = clr_idx;
      mem_wd  = '0;
    end else if (wr_acc && in_range) begin
      mem_we  = {!bus.UB, !bus.LB};
    end else if (load_fire) begin
      mem_we  = '1;
      mem_idx = bus.load_addr;
      mem_wd  = bus.load_data;
    end
  end

  always_ff @(posedge Clk) begin
    if (mem_we[1]) mem[mem_idx][15:8] <= mem_wd[15:8];
    if (mem_we[0]) mem[mem_idx][7:0]  <= mem_wd[7:0];
  end

  always_ff @(posedge Clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= CLEAR;
      clr_idx <= '0;
      rd_q    <= '0;
      drv_q   <= '0;
      busy    <= 1'b1;
      oob_err <= 1'b0;
    end else begin
      if ((wr_acc || rd_acc) && !in_range) oob_err <= 1'b1;

      if (rd_acc) begin
        drv_q <= {!bus.UB, !bus.LB};
        rd_q  <= (state == IDLE && in_range) ? mem[idx] : '0;
      end else begin
        drv_q <= '0;
      end

      case (state)
        CLEAR: begin
          clr_idx <= clr_idx + AW'(1);
          if (clr_idx == AW'(DEPTH - 1)) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign I_O[15:8] = drv_q[1] ? rd_q[15:8] : 'z;
  assign I_O[7:0]  = drv_q[0] ? rd_q[7:0]  : 'z;

endmodule

// File: tb/tb_sram_responder.sv
// Randomised scoreboard bench for sram_responder: stimulus pushes expected read words,
// a monitor pops them when a read was sampled; undriven lanes read back as 1s via tri1.
module tb_sram_responder;
  localparam int DEPTH = 1024;
  localparam int AW    = 10;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic busy, oob_err;
  logic tb_oe = 1'b0;
  logic [15:0] tb_dat = '0;
  tri1  [15:0] io;

  sram_if #(.AW(AW)) bus ();

  assign io = tb_oe ? tb_dat : 'z;

  sram_responder #(.DEPTH(DEPTH), .AW(AW)) dut (
    .Clk(clk), .Reset(rst), .bus(bus), .I_O(io), .busy(busy), .oob_err(oob_err)
  );

  always #5 clk = ~clk;

  int unsigned n_cmp = 0;
  int unsigned n_fail = 0;
  logic [15:0] ref_mem [DEPTH];
  bit          ref_oob;
  int          edge_cnt;
  bit          last_rd;
  logic [15:0] exp_q [$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] lanes(input logic [15:0] v, input bit ub, input bit lb);
    return {ub ? 8'hFF : v[15:8], lb ? 8'hFF : v[7:0]};
  endfunction

  // One bus cycle, called at a negedge; returns at the following negedge.
  task automatic apply(input bit ce, input bit we, input bit oe, input bit ub, input bit lb,
                       input logic [19:0] a, input logic [15:0] d,
                       input bit lv, input logic [AW-1:0] la, input logic [15:0] ld);
    bit idle_now, live, in_rng;
    logic [15:0] v;
    bus.CE = ce; bus.WE = we; bus.OE = oe; bus.UB = ub; bus.LB = lb; bus.A = a;
    bus.load_valid = lv; bus.load_addr = la; bus.load_data = ld;
    tb_dat = d;
    tb_oe  = !ce && !we;
    idle_now = (edge_cnt >= DEPTH + 2);
    #1 chk("load_ready", {31'd0, bus.load_ready}, {31'd0, ce && idle_now});
    edge_cnt++;
    live   = (edge_cnt > 2);
    in_rng = (a < DEPTH);
    if (!ce && (!we || !oe) && !in_rng && live) ref_oob = 1'b1;
    if (!ce && !we) begin
      if (in_rng && idle_now) begin
        if (!ub) ref_mem[a[AW-1:0]][15:8] = d[15:8];
        if (!lb) ref_mem[a[AW-1:0]][7:0]  = d[7:0];
      end
    end else if (!ce && !oe) begin
      v = (idle_now && in_rng) ? ref_mem[a[AW-1:0]] : 16'h0000;
      exp_q.push_back(lanes(v, ub, lb));
    end
    if (ce && lv && idle_now) ref_mem[la] = ld;
    last_rd = !ce && we && !oe;
    @(posedge clk);
    #1 tb_oe = 1'b0;
    @(negedge clk);
    chk("oob_err", {31'd0, oob_err}, {31'd0, ref_oob});
  endtask

  task automatic idle_cyc();
    apply(1, 1, 1, 1, 1, '0, '0, 0, '0, '0);
  endtask

  task automatic rd(input logic [19:0] a, input bit ub, input bit lb);
    apply(0, 1, 0, ub, lb, a, '0, 0, '0, '0);
  endtask

  task automatic wr(input logic [19:0] a, input logic [15:0] d, input bit ub, input bit lb);
    if (last_rd) idle_cyc();
    apply(0, 0, $urandom_range(0, 1) == 1, ub, lb, a, d, 0, '0, '0);
  endtask

  task automatic ld(input logic [AW-1:0] la, input logic [15:0] d);
    apply(1, 1, 1, 1, 1, '0, '0, 1, la, d);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    bus.CE = 1; bus.WE = 1; bus.OE = 1; bus.UB = 1; bus.LB = 1; bus.A = '0;
    bus.load_valid = 0; bus.load_addr = '0; bus.load_data = '0;
    tb_oe = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_busy", {31'd0, busy}, 32'd1);
    chk("rst_oob", {31'd0, oob_err}, 32'd0);
    chk("rst_load_ready", {31'd0, bus.load_ready}, 32'd0);
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
    ref_oob  = 1'b0;
    edge_cnt = 0;
    last_rd  = 1'b0;
    rst = 1'b1;
  endtask

  task automatic wait_clear();
    while (busy && edge_cnt < 3 * DEPTH) idle_cyc();
    chk("clear_cycles", edge_cnt, DEPTH + 2);
  endtask

  // Monitor: decides from the strobes whether a read was sampled at each edge.
  initial begin
    bit rd_s;
    logic [15:0] e;
    forever begin
      @(posedge clk);
      rd_s = !bus.CE && bus.WE && !bus.OE;
      #2;
      if (rd_s) begin
        if (exp_q.size() == 0) begin
          n_cmp++; n_fail++;
          $display("FAIL read_unexpected: got %h expected no read", io);
        end else begin
          e = exp_q.pop_front();
          chk("read_data", io, e);
        end
      end else begin
        chk("bus_release", io, 16'hFFFF);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned r;
    logic [19:0] a;
    bit ub, lb;
    bus.CE = 1; bus.WE = 1; bus.OE = 1; bus.UB = 1; bus.LB = 1; bus.A = '0;
    bus.load_valid = 0; bus.load_addr = '0; bus.load_data = '0;
    @(negedge clk);
    do_reset();

    // Clear phase: reads give zero, writes are dropped.
    repeat (5) idle_cyc();
    rd(5, 0, 0);
    wr(7, 16'h1111, 0, 0);
    wait_clear();
    rd(5, 0, 0);
    rd(7, 0, 0);

    ld(0, 16'h1234);
    ld(1, 16'hABCD);
    rd(0, 0, 0);
    rd(1, 0, 0);

    wr(2, 16'hBEEF, 0, 1);
    wr(3, 16'h00FF, 0, 0);
    rd(2, 0, 0);
    rd(2, 1, 0);
    rd(3, 0, 1);
    rd(3, 1, 1);

    wr(4, 16'h5A5A, 0, 0);
    rd(4, 0, 0);

    rd(20'h00400, 0, 0);
    rd(1, 0, 0);
    wr(6, 16'h4242, 0, 0);
    rd(6, 0, 0);

    // Load held off while the CPU is selected, then taken once CE rises.
    apply(0, 1, 0, 0, 0, 20'd9, '0, 1, AW'(9), 16'h7777);
    ld(9, 16'h7777);
    rd(9, 0, 0);

    for (int i = 0; i < 1500; i++) begin
      r  = $urandom_range(0, 9);
      a  = ($urandom_range(0, 19) == 0) ? 20'($urandom) : 20'($urandom_range(0, 31));
      ub = ($urandom_range(0, 3) == 0);
      lb = ($urandom_range(0, 3) == 0);
      if (r < 4)      rd(a, ub, lb);
      else if (r < 7) wr(a, 16'($urandom), ub, lb);
      else if (r < 9) ld(AW'($urandom_range(0, 31)), 16'($urandom));
      else            apply(0, 1, 1, ub, lb, a, '0, 0, '0, '0);
    end

    // Reset part-way through the clear restarts it from index 0.
    if (last_rd) idle_cyc();
    do_reset();
    repeat (502) idle_cyc();
    do_reset();
    wait_clear();
    rd(0, 0, 0);
    rd(2, 0, 0);
    rd(9, 0, 0);

    repeat (2) idle_cyc();
    chk("queue_empty", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
